// File: rtl/prirv32_idu.sv
`default_nettype none
// ============================================================================
//  Module   : prirv32_idu
//  Purpose  : priRV32 decode stage - one-hot decode, immediate extraction,
//             32x32 register file with writeback bypass, single output stage.
//  Option   : define PRIRV32_IDU_CSR_EN to decode the six CSR instructions.
//  Revision : 1.0 - initial release
// ============================================================================
module prirv32_idu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        if_valid_i,
    output logic        if_ready_o,
    input  logic [31:0] if_instr_i,
    input  logic [31:0] if_pc_i,
    input  logic        flush_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [31:0] imm_decoded,
    output logic [31:0] rs1_decoded,
    output logic [31:0] rs2_decoded,
    output logic [31:0] pc_latched,
    output logic [4:0]  rs2_reg,
    output logic [4:0]  rd_reg,
    output logic [46:0] instrset_latched,
    output logic        illegal_o
);

    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_opimm  = 7'b0010011;
    localparam logic [6:0] c_op_op     = 7'b0110011;
    localparam logic [6:0] c_op_misc   = 7'b0001111;
    localparam logic [6:0] c_op_system = 7'b1110011;
    localparam logic [6:0] c_f7_zero   = 7'b0000000;
    localparam logic [6:0] c_f7_alt    = 7'b0100000;

    logic [31:0] r_rf [32];
    logic        r_ex_valid;
    logic        r_illegal;
    logic [46:0] r_instrset;
    logic [31:0] r_imm;
    logic [31:0] r_rs1_val;
    logic [31:0] r_rs2_val;
    logic [31:0] r_pc;
    logic [4:0]  r_rs1_idx;
    logic [4:0]  r_rs2_idx;
    logic [4:0]  r_rd;

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rs1_idx;
    logic [4:0]  w_rs2_idx;
    logic [46:0] w_dec;
    logic [31:0] w_imm;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic        w_ready;
    logic        w_accept;
    logic        w_hold;
    logic        w_wb_act;

    assign w_op      = if_instr_i[6:0];
    assign w_f3      = if_instr_i[14:12];
    assign w_f7      = if_instr_i[31:25];
    assign w_rs1_idx = if_instr_i[19:15];
    assign w_rs2_idx = if_instr_i[24:20];

    assign w_ready   = !r_ex_valid || ex_ready_i;
    assign w_accept  = if_valid_i && w_ready && !flush_i;
    assign w_hold    = r_ex_valid && !ex_ready_i;
    assign w_wb_act  = wb_we_i && (wb_rd_i != 5'd0);

    always_comb begin
        w_dec = '0;
        case (w_op)
            c_op_lui:   w_dec[46] = 1'b1;
            c_op_auipc: w_dec[45] = 1'b1;
            c_op_jal:   w_dec[44] = 1'b1;
            c_op_jalr:  w_dec[43] = (w_f3 == 3'd0);
            c_op_branch: begin
                case (w_f3)
                    3'd0: w_dec[42] = 1'b1;
                    3'd1: w_dec[41] = 1'b1;
                    3'd4: w_dec[40] = 1'b1;
                    3'd5: w_dec[39] = 1'b1;
                    3'd6: w_dec[38] = 1'b1;
                    3'd7: w_dec[37] = 1'b1;
                    default: ;
                endcase
            end
            c_op_load: begin
                case (w_f3)
                    3'd0: w_dec[36] = 1'b1;
                    3'd1: w_dec[35] = 1'b1;
                    3'd2: w_dec[34] = 1'b1;
                    3'd4: w_dec[33] = 1'b1;
                    3'd5: w_dec[32] = 1'b1;
                    default: ;
                endcase
            end
            c_op_store: begin
                case (w_f3)
                    3'd0: w_dec[31] = 1'b1;
                    3'd1: w_dec[30] = 1'b1;
                    3'd2: w_dec[29] = 1'b1;
                    default: ;
                endcase
            end
            c_op_opimm: begin
                case (w_f3)
                    3'd0: w_dec[28] = 1'b1;
                    3'd2: w_dec[27] = 1'b1;
                    3'd3: w_dec[26] = 1'b1;
                    3'd4: w_dec[25] = 1'b1;
                    3'd6: w_dec[24] = 1'b1;
                    3'd7: w_dec[23] = 1'b1;
                    3'd1: w_dec[22] = (w_f7 == c_f7_zero);
                    3'd5: begin
                        w_dec[21] = (w_f7 == c_f7_zero);
                        w_dec[20] = (w_f7 == c_f7_alt);
                    end
                    default: ;
                endcase
            end
            c_op_op: begin
                case ({w_f7, w_f3})
                    {c_f7_zero, 3'd0}: w_dec[19] = 1'b1;
                    {c_f7_alt,  3'd0}: w_dec[18] = 1'b1;
                    {c_f7_zero, 3'd1}: w_dec[17] = 1'b1;
                    {c_f7_zero, 3'd2}: w_dec[16] = 1'b1;
                    {c_f7_zero, 3'd3}: w_dec[15] = 1'b1;
                    {c_f7_zero, 3'd4}: w_dec[14] = 1'b1;
                    {c_f7_zero, 3'd5}: w_dec[13] = 1'b1;
                    {c_f7_alt,  3'd5}: w_dec[12] = 1'b1;
                    {c_f7_zero, 3'd6}: w_dec[11] = 1'b1;
                    {c_f7_zero, 3'd7}: w_dec[10] = 1'b1;
                    default: ;
                endcase
            end
            c_op_misc: begin
                w_dec[9] = (w_f3 == 3'd0);
                w_dec[8] = (w_f3 == 3'd1);
            end
            c_op_system: begin
                // ecall/ebreak require every non-opcode field to be zero except imm[0]
                w_dec[7] = (if_instr_i[31:7] == 25'd0);
                w_dec[6] = (if_instr_i[31:7] == 25'h0002000);
`ifdef PRIRV32_IDU_CSR_EN
                case (w_f3)
                    3'd1: w_dec[5] = 1'b1;
                    3'd2: w_dec[4] = 1'b1;
                    3'd3: w_dec[3] = 1'b1;
                    3'd5: w_dec[2] = 1'b1;
                    3'd6: w_dec[1] = 1'b1;
                    3'd7: w_dec[0] = 1'b1;
                    default: ;
                endcase
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        w_imm = '0;
        if (w_dec[46] || w_dec[45]) begin
            w_imm = {if_instr_i[31:12], 12'b0};
        end else if (w_dec[44]) begin
            w_imm = {{12{if_instr_i[31]}}, if_instr_i[19:12], if_instr_i[20],
                     if_instr_i[30:21], 1'b0};
        end else if (|w_dec[42:37]) begin
            w_imm = {{20{if_instr_i[31]}}, if_instr_i[7], if_instr_i[30:25],
                     if_instr_i[11:8], 1'b0};
        end else if (|w_dec[31:29]) begin
            w_imm = {{21{if_instr_i[31]}}, if_instr_i[30:25], if_instr_i[11:7]};
        end else if (w_dec[43] || (|w_dec[36:32]) || (|w_dec[28:20])) begin
            w_imm = {{21{if_instr_i[31]}}, if_instr_i[30:20]};
        end else if (|w_dec[5:0]) begin
            w_imm = {20'd0, if_instr_i[31:20]};
        end
    end

    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_rs1_idx != 5'd0) begin
            w_rs1_val = (w_wb_act && wb_rd_i == w_rs1_idx) ? wb_data_i : r_rf[w_rs1_idx];
        end
        if (w_rs2_idx != 5'd0) begin
            w_rs2_val = (w_wb_act && wb_rd_i == w_rs2_idx) ? wb_data_i : r_rf[w_rs2_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wb_act) begin
            r_rf[wb_rd_i] <= wb_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_illegal  <= 1'b0;
            r_instrset <= '0;
            r_imm      <= '0;
            r_rs1_val  <= '0;
            r_rs2_val  <= '0;
            r_pc       <= RESET_PC;
            r_rs1_idx  <= '0;
            r_rs2_idx  <= '0;
            r_rd       <= '0;
        end else if (flush_i) begin
            r_ex_valid <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_illegal  <= ~|w_dec;
            r_instrset <= w_dec;
            r_imm      <= w_imm;
            r_rs1_val  <= w_rs1_val;
            r_rs2_val  <= w_rs2_val;
            r_pc       <= if_pc_i;
            r_rs1_idx  <= w_rs1_idx;
            r_rs2_idx  <= w_rs2_idx;
            r_rd       <= if_instr_i[11:7];
        end else begin
            if (ex_ready_i) begin
                r_ex_valid <= 1'b0;
            end
            // keep held operands current with writebacks that land while stalled
            if (w_hold && w_wb_act && wb_rd_i == r_rs1_idx) begin
                r_rs1_val <= wb_data_i;
            end
            if (w_hold && w_wb_act && wb_rd_i == r_rs2_idx) begin
                r_rs2_val <= wb_data_i;
            end
        end
    end

    assign if_ready_o       = w_ready;
    assign ex_valid_o       = r_ex_valid;
    assign illegal_o        = r_illegal;
    assign instrset_latched = r_instrset;
    assign imm_decoded      = r_imm;
    assign rs1_decoded      = r_rs1_val;
    assign rs2_decoded      = r_rs2_val;
    assign pc_latched       = r_pc;
    assign rs2_reg          = r_rs2_idx;
    assign rd_reg           = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_prirv32_idu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prirv32_idu
//  Purpose  : self-checking bench for prirv32_idu (decode table + scoreboard).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prirv32_idu;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0080;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        if_valid_i;
    logic        if_ready_o;
    logic [31:0] if_instr_i;
    logic [31:0] if_pc_i;
    logic        flush_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [31:0] imm_decoded;
    logic [31:0] rs1_decoded;
    logic [31:0] rs2_decoded;
    logic [31:0] pc_latched;
    logic [4:0]  rs2_reg;
    logic [4:0]  rd_reg;
    logic [46:0] instrset_latched;
    logic        illegal_o;

    prirv32_idu #(.RESET_PC(C_RESET_PC)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
        .if_instr_i(if_instr_i), .if_pc_i(if_pc_i), .flush_i(flush_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .imm_decoded(imm_decoded), .rs1_decoded(rs1_decoded),
        .rs2_decoded(rs2_decoded), .pc_latched(pc_latched),
        .rs2_reg(rs2_reg), .rd_reg(rd_reg),
        .instrset_latched(instrset_latched), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [46:0] vec;
        logic [31:0] imm;
        logic        chk_imm;
        logic        ill;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    vec_t        tbl [16];
    vec_t        cur;
    exp_t        q [$];
    exp_t        e;
    logic [31:0] rf [32];
    logic        m_ready;

    function automatic logic [46:0] oh(input int b);
        return 47'd1 << b;
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [46:0] vec, input logic [31:0] imm,
                                input logic chk_imm, input logic ill);
        vec_t t;
        t.instr = instr; t.pc = pc; t.vec = vec; t.imm = imm;
        t.chk_imm = chk_imm; t.ill = ill;
        return t;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // scoreboard: push on accept, pop on consume, refresh the head while held
    always @(negedge clk_i) begin
        if (!rst_n) begin
            q.delete();
            for (int r = 0; r < 32; r++) rf[r] = '0;
        end else begin
            check("ex_valid", 64'(ex_valid_o), 64'(q.size() != 0));
            m_ready = (q.size() == 0) || ex_ready_i;
            check("if_ready", 64'(if_ready_o), 64'(m_ready));
            if (flush_i) begin
                if (q.size() != 0) void'(q.pop_front());
            end else if (q.size() != 0 && ex_ready_i) begin
                e = q.pop_front();
                check("vector",  64'(instrset_latched), 64'(e.v.vec));
                check("illegal", 64'(illegal_o), 64'(e.v.ill));
                check("pc",      64'(pc_latched), 64'(e.v.pc));
                check("rd",      64'(rd_reg), 64'(e.v.instr[11:7]));
                check("rs2_reg", 64'(rs2_reg), 64'(e.v.instr[24:20]));
                check("rs1_val", 64'(rs1_decoded), 64'(e.rs1v));
                check("rs2_val", 64'(rs2_decoded), 64'(e.rs2v));
                if (e.v.chk_imm) check("imm", 64'(imm_decoded), 64'(e.v.imm));
            end else if (q.size() != 0 && wb_we_i && wb_rd_i != 5'd0) begin
                e = q[0];
                if (wb_rd_i == e.v.instr[19:15]) e.rs1v = wb_data_i;
                if (wb_rd_i == e.v.instr[24:20]) e.rs2v = wb_data_i;
                q[0] = e;
            end
            if (wb_we_i && wb_rd_i != 5'd0) rf[wb_rd_i] = wb_data_i;
            if (if_valid_i && m_ready && !flush_i) begin
                e.v    = cur;
                e.rs1v = rf[cur.instr[19:15]];
                e.rs2v = rf[cur.instr[24:20]];
                q.push_back(e);
            end
        end
    end

    task automatic send(input vec_t v);
        logic acc;
        int   n;
        cur        = v;
        if_valid_i = 1'b1;
        if_instr_i = v.instr;
        if_pc_i    = v.pc;
        n = 0;
        forever begin
            @(negedge clk_i);
            acc = if_ready_o && !flush_i;
            @(posedge clk_i);
            #1;
            if (acc) break;
            n++;
            if (n > 50) begin
                total++; bad++;
                $display("FAIL accept_timeout got=stalled want=accepted");
                break;
            end
        end
    endtask

    task automatic idle();
        if_valid_i = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        wb_we_i = 1'b1; wb_rd_i = rd; wb_data_i = d;
        @(posedge clk_i); #1;
        wb_we_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = mk(32'hFFB00093, 32'h100, oh(28), 32'hFFFFFFFB, 1'b1, 1'b0); // addi x1,x0,-5
        tbl[1]  = mk(32'h12345137, 32'h104, oh(46), 32'h12345000, 1'b1, 1'b0); // lui
        tbl[2]  = mk(32'h010000EF, 32'h108, oh(44), 32'h00000010, 1'b1, 1'b0); // jal +16
        tbl[3]  = mk(32'hFE000CE3, 32'h10C, oh(42), 32'hFFFFFFF8, 1'b1, 1'b0); // beq -8
        tbl[4]  = mk(32'h00512623, 32'h110, oh(29), 32'h0000000C, 1'b1, 1'b0); // sw x5,12(x2)
        tbl[5]  = mk(32'hFFC0A183, 32'h114, oh(34), 32'hFFFFFFFC, 1'b1, 1'b0); // lw x3,-4(x1)
        tbl[6]  = mk(32'h4030D213, 32'h118, oh(20), 32'h00000403, 1'b1, 1'b0); // srai x4,x1,3
        tbl[7]  = mk(32'h402081B3, 32'h11C, oh(18), 32'h00000000, 1'b1, 1'b0); // sub x3,x1,x2
        tbl[8]  = mk(32'h00000073, 32'h120, oh(7),  32'h00000000, 1'b1, 1'b0); // ecall
        tbl[9]  = mk(32'hFFFFFFFF, 32'h124, 47'd0,  32'h00000000, 1'b0, 1'b1); // illegal
`ifdef PRIRV32_IDU_CSR_EN
        tbl[10] = mk(32'h34011073, 32'h128, oh(5),  32'h00000340, 1'b1, 1'b0); // csrrw
`else
        tbl[10] = mk(32'h34011073, 32'h128, 47'd0,  32'h00000000, 1'b0, 1'b1); // csrrw
`endif
        tbl[11] = mk(32'h0FF0000F, 32'h12C, oh(9),  32'h00000000, 1'b0, 1'b0); // fence
        tbl[12] = mk(32'h0020F3B3, 32'h130, oh(10), 32'h00000000, 1'b1, 1'b0); // and x7,x1,x2
        tbl[13] = mk(32'h00008067, 32'h134, oh(43), 32'h00000000, 1'b1, 1'b0); // jalr x0,0(x1)
        tbl[14] = mk(32'h02101093, 32'h138, 47'd0,  32'h00000000, 1'b0, 1'b1); // bad slli funct7
        tbl[15] = mk(32'h00100073, 32'h13C, oh(6),  32'h00000000, 1'b1, 1'b0); // ebreak

        rst_n = 1'b0; if_valid_i = 1'b0; if_instr_i = '0; if_pc_i = '0;
        flush_i = 1'b0; wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
        ex_ready_i = 1'b1;
        cur = tbl[0];

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ex_valid", 64'(ex_valid_o), 64'd0);
        check("rst_illegal",  64'(illegal_o), 64'd0);
        check("rst_if_ready", 64'(if_ready_o), 64'd1);
        check("rst_pc",       64'(pc_latched), 64'(C_RESET_PC));
        check("rst_imm",      64'(imm_decoded), 64'd0);
        check("rst_vector",   64'(instrset_latched), 64'd0);
        rst_n = 1'b1;

        wb(5'd1, 32'h11);
        wb(5'd2, 32'h22);
        wb(5'd5, 32'h55);

        // decode table, back-to-back at full throughput
        for (int i = 0; i < 16; i++) send(tbl[i]);
        idle();
        repeat (2) @(posedge clk_i);
        #1;

        // writeback bypass into the accepting instruction
        wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h1234;
        send(mk(32'h00528333, 32'h180, oh(19), 32'h0, 1'b1, 1'b0)); // add x6,x5,x5
        wb_we_i = 1'b0;
        check("bypass_rs1", 64'(rs1_decoded), 64'h1234);
        check("bypass_rs2", 64'(rs2_decoded), 64'h1234);
        idle();
        @(posedge clk_i); #1;

        // stall for three cycles with a stream waiting, refreshing held rs2
        ex_ready_i = 1'b0;
        send(mk(32'h402081B3, 32'h200, oh(18), 32'h0, 1'b1, 1'b0)); // sub x3,x1,x2
        fork
            begin
                send(mk(32'h00528333, 32'h204, oh(19), 32'h0, 1'b1, 1'b0));
                send(mk(32'h0020F3B3, 32'h208, oh(10), 32'h0, 1'b1, 1'b0));
                idle();
            end
            begin
                wb_we_i = 1'b1; wb_rd_i = 5'd2; wb_data_i = 32'h77;
                @(negedge clk_i);
                check("hold_ready", 64'(if_ready_o), 64'd0);
                check("hold_pc", 64'(pc_latched), 64'h200);
                @(posedge clk_i); #1;
                wb_we_i = 1'b0;
                @(negedge clk_i);
                check("hold_rs2_refresh", 64'(rs2_decoded), 64'h77);
                check("hold_rs1_kept", 64'(rs1_decoded), 64'h11);
                @(negedge clk_i);
                check("hold_pc_late", 64'(pc_latched), 64'h200);
                @(posedge clk_i); #1;
                ex_ready_i = 1'b1;
            end
        join
        @(posedge clk_i); #1;

        // flush kills the held instruction and the incoming one, writeback still lands
        ex_ready_i = 1'b0;
        send(mk(32'hFE000CE3, 32'h300, oh(42), 32'hFFFFFFF8, 1'b1, 1'b0));
        check("beq_vector", 64'(instrset_latched), 64'(oh(42)));
        check("beq_imm", 64'(imm_decoded), 64'hFFFFFFF8);
        flush_i = 1'b1; if_valid_i = 1'b1; if_instr_i = 32'hFFB00093; if_pc_i = 32'h304;
        wb_we_i = 1'b1; wb_rd_i = 5'd9; wb_data_i = 32'h99;
        @(posedge clk_i); #1;
        flush_i = 1'b0; if_valid_i = 1'b0; wb_we_i = 1'b0; ex_ready_i = 1'b1;
        @(negedge clk_i);
        check("flush_kill", 64'(ex_valid_o), 64'd0);
        @(posedge clk_i); #1;
        send(mk(32'h00048533, 32'h308, oh(19), 32'h0, 1'b1, 1'b0)); // add x10,x9,x0
        check("flush_wb_commit", 64'(rs1_decoded), 64'h99);

        // x0 stays zero
        idle();
        wb(5'd0, 32'hDEAD);
        send(mk(32'h000000B3, 32'h400, oh(19), 32'h0, 1'b1, 1'b0)); // add x1,x0,x0
        check("x0_rs1", 64'(rs1_decoded), 64'd0);
        check("x0_rs2", 64'(rs2_decoded), 64'd0);
        idle();
        @(posedge clk_i); #1;

        // reset while holding drops the instruction and clears the register file
        ex_ready_i = 1'b0;
        send(mk(32'hFFB00093, 32'h500, oh(28), 32'hFFFFFFFB, 1'b1, 1'b0));
        idle();
        rst_n = 1'b0;
        @(posedge clk_i); #1;
        check("reset_drop", 64'(ex_valid_o), 64'd0);
        check("reset_pc", 64'(pc_latched), 64'(C_RESET_PC));
        rst_n = 1'b1; ex_ready_i = 1'b1;
        send(mk(32'h00528333, 32'h600, oh(19), 32'h0, 1'b1, 1'b0));
        check("rf_cleared", 64'(rs1_decoded), 64'd0);
        idle();
        repeat (2) @(posedge clk_i);

        @(negedge clk_i);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prirv32_idu.md
# prirv32_idu

Instruction decode stage of the priRV32 core, directly upstream of `priRV32_EXU`. It accepts a fetched instruction word and PC through a valid/ready handshake, decodes the instruction into the 47-bit one-hot instruction-set vector, and extracts the immediate. It reads both source operands from an internal 32×32 register file and presents everything to the execute stage from a single output register stage. The block also owns the register-file write port driven by writeback.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: value loaded into `pc_latched` at reset.

Ports:
- `clk_i`, in, 1: core clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `if_valid_i`, in, 1: fetch presents an instruction.
- `if_ready_o`, out, 1: the decoder accepts this cycle.
- `if_instr_i`, in, 32: instruction word.
- `if_pc_i`, in, 32: PC of that instruction.
- `flush_i`, in, 1: branch/jump redirect; kills the held and the incoming instruction.
- `wb_we_i`, in, 1: register-file write enable.
- `wb_rd_i`, in, 5: write address.
- `wb_data_i`, in, 32: write data.
- `ex_valid_o`, out, 1: output register holds a valid instruction.
- `ex_ready_i`, in, 1: execute consumes this cycle.
- `imm_decoded`, out, 32: sign-extended immediate.
- `rs1_decoded`, out, 32: rs1 operand value.
- `rs2_decoded`, out, 32: rs2 operand value.
- `pc_latched`, out, 32: PC of the held instruction.
- `rs2_reg`, out, 5: instr[24:20]; also the shift amount for shift-immediate instructions.
- `rd_reg`, out, 5: instr[11:7].
- `instrset_latched`, out, 47: one-hot decode vector.
- `illegal_o`, out, 1: held instruction matched no encoding.

## Operation
- Accept condition: `if_valid_i && if_ready_o && !flush_i`. Ready is defined as `if_ready_o = !ex_valid_o || ex_ready_i`, purely combinational.
- On accept, the output register loads:
  - the decode vector;
  - the immediate;
  - the operands read from the register file;
  - `if_pc_i`, rs2 field and rd field.
  - `ex_valid_o` is set to 1.
- If execute consumes (`ex_ready_i`) and nothing new is accepted, `ex_valid_o` goes to 0; the data fields hold their values.
- `instrset_latched` bit order, MSB [46] down to LSB [0]: lui, auipc, jal, jalr, beq, bne, blt, bge, bltu, bgeu, lb, lh, lw, lbu, lhu, sb, sh, sw, addi, slti, sltiu, xori, ori, andi, slli, srli, srai, add, sub, sll, slt, sltu, xor, srl, sra, or, and, fence, fence.i, ecall, ebreak, csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci.
- Decoding is a full match on opcode, funct3 and funct7 (funct7 for R-type and shift-immediate). At most one bit is set.
- Illegal encodings:
  - all vector bits are 0 and `illegal_o=1`;
  - `ex_valid_o` is still set, so execute sees a no-op.
- Immediate by format:
  - I: sext(instr[31:20]).
  - S: sext({[31:25],[11:7]}).
  - B: sext({[31],[7],[30:25],[11:8],0}).
  - U: {[31:12],12'b0}.
  - J: sext({[31],[19:12],[20],[30:21],0}).
  - CSR: zero-extended instr[31:20].
  - R-type and system: 0.
- Register file:
  - x0 always reads 0; writes to x0 are ignored.
  - Same-cycle bypass: if `wb_we_i` and `wb_rd_i`≠0 equals the rs1/rs2 field being read, `wb_data_i` is captured.
- Held-operand refresh: while the instruction is held (`ex_valid_o && !ex_ready_i`), a writeback whose rd matches the held rs1/rs2 field (≠0) updates `rs1_decoded`/`rs2_decoded` in the same edge.
- Hazards against instructions already in execute are not detected here; the hazard unit withholds `if_valid_i`.

## Timing
- Latency is 1 cycle, from the accept edge to `ex_valid_o=1` with all fields valid.
- Sustained throughput is 1 instruction/cycle when `ex_ready_i=1`.
- Reset values of outputs and state:
  - `ex_valid_o=0`, `illegal_o=0`;
  - all data outputs 0 except `pc_latched=RESET_PC`;
  - all 32 registers cleared to 0.
  - `if_ready_o` is 1 during and after reset (as combinationally derived from `ex_valid_o=0`).
- Flush has priority over everything:
  - the next edge clears `ex_valid_o`;
  - no accept occurs in the flush cycle;
  - a writeback in the same cycle still commits.
- Reset asserted mid-hold drops the held instruction at the next edge.
- A simultaneous consume and accept replaces the held instruction with no bubble.

## Configuration
- `PRIRV32_IDU_CSR_EN` defined: the six CSR instructions decode to bits [5:0] with the CSR immediate.
- Undefined: bits [5:0] are tied to 0 and CSR encodings raise `illegal_o`. ecall/ebreak are unaffected.

## Test plan
- Reset, then `addi x1,x0,-5` (0xFFB00093) at pc 0x100 → next cycle `ex_valid_o=1`, bit[28] set only, imm=0xFFFFFFFB, `pc_latched`=0x100, `rd_reg`=1.
- Write x5=0x1234 via writeback in the same cycle as accepting `add x6,x5,x5` → `rs1_decoded`=`rs2_decoded`=0x1234 (bypass).
- Hold with `ex_ready_i=0` for 3 cycles with a back-to-back stream → `if_ready_o=0`, outputs stable. A writeback to the held rs2 during the hold updates `rs2_decoded`. Release → one instruction per cycle, none lost or duplicated.
- `beq` with imm −8 (0xFE000CE3) → bit[42] set, imm=0xFFFFFFF8. Assert `flush_i` while held → `ex_valid_o=0` next cycle.
- Word 0xFFFFFFFF → `illegal_o=1`, vector 0. `csrrw` (0x34011073) → bit[5] and imm=0x340 with the macro; `illegal_o=1` and vector 0 without it.
- Write x0=0xDEAD, then decode `add x1,x0,x0` → both operands 0.
